// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite master bridge.
// Contents:
//   DEFAULT_TIMEOUT - default watchdog limit, in cycles per waiting state
//   state_t         - 3-bit FSM state encoding used by the bridge
package axi_lite_pkg;

  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/axi_watchdog.sv
// Saturating per-state cycle counter used to abort stalled transactions.
// Ports:
//   clock   - system clock
//   reset   - synchronous, active-low
//   clear   - restart the count from zero (asserted on every state change)
//   enable  - count this cycle (asserted while waiting on the slave)
//   expired - this is the TIMEOUT-th consecutive enabled cycle; the owner
//             leaves the waiting state on this edge unless a handshake wins
module axi_watchdog
  import axi_lite_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] LAST  = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count;

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values of its inputs, whatever the statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // The count holds the number of cycles already spent in the state, so it
  // equals TIMEOUT-1 during the TIMEOUT-th cycle.
  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding CPU-to-AXI4-Lite master bridge.
// Ports:
//   clock, reset                 - system clock; synchronous active-low reset
//   req_valid/req_ready          - CPU request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata  - request direction, address, write data
//   resp_valid                   - one-cycle completion pulse
//   resp_err                     - with resp_valid: 1 = watchdog abort
//   resp_rdata                   - with resp_valid on reads: read data
//   AW*/W*/B*/AR*/R*             - AXI4-Lite master channels to the slave
module axi_lite_master_bridge
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] AWaddr,
  output logic              AWvalid,
  input  logic              AWready,
  output logic [DATA_W-1:0] Wdata,
  output logic              Wvalid,
  input  logic              Wready,
  input  logic              Bvalid,
  output logic              Bready,
  output logic [ADDR_W-1:0] ARaddr,
  output logic              ARvalid,
  input  logic              ARready,
  input  logic [DATA_W-1:0] Rdata,
  input  logic              Rvalid,
  output logic              Rready
);

  state_t state, state_next;

  logic              aw_valid_next, w_valid_next, b_ready_next;
  logic              ar_valid_next, r_ready_next;
  logic              resp_err_next;
  logic [DATA_W-1:0] resp_rdata_next, w_data_next;
  logic [ADDR_W-1:0] aw_addr_next, ar_addr_next;
  logic              aw_ok, w_ok;
  logic              wd_clear, wd_enable, wd_expired;

  // Held low during reset so no request can be taken while the bridge is
  // being cleared.
  assign req_ready  = (state == ST_IDLE) && reset;
  assign resp_valid = (state == ST_DONE);

  assign wd_enable = (state == ST_WRITE) || (state == ST_WRESP) ||
                     (state == ST_RADDR) || (state == ST_RDATA);
  assign wd_clear  = (state_next != state);

  axi_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // A write channel counts as done once its valid has already dropped or
  // its handshake happens this cycle; the two channels finish independently.
  assign aw_ok = !AWvalid || AWready;
  assign w_ok  = !Wvalid  || Wready;

  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next      = state;
    aw_valid_next   = AWvalid;
    w_valid_next    = Wvalid;
    b_ready_next    = Bready;
    ar_valid_next   = ARvalid;
    r_ready_next    = Rready;
    resp_err_next   = resp_err;
    resp_rdata_next = resp_rdata;
    aw_addr_next    = AWaddr;
    w_data_next     = Wdata;
    ar_addr_next    = ARaddr;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_we) begin
            aw_addr_next  = req_addr;
            w_data_next   = req_wdata;
            aw_valid_next = 1'b1;
            w_valid_next  = 1'b1;
            state_next    = ST_WRITE;
          end else begin
            ar_addr_next  = req_addr;
            ar_valid_next = 1'b1;
            state_next    = ST_RADDR;
          end
        end
      end

      ST_WRITE: begin
        if (aw_ok && w_ok) begin
          aw_valid_next = 1'b0;
          w_valid_next  = 1'b0;
          b_ready_next  = 1'b1;
          state_next    = ST_WRESP;
        end else if (wd_expired) begin
          aw_valid_next   = 1'b0;
          w_valid_next    = 1'b0;
          resp_err_next   = 1'b1;
          resp_rdata_next = '0;
          state_next      = ST_DONE;
        end else begin
          aw_valid_next = AWvalid && !AWready;
          w_valid_next  = Wvalid && !Wready;
        end
      end

      ST_WRESP: begin
        if (Bvalid) begin
          b_ready_next  = 1'b0;
          resp_err_next = 1'b0;
          state_next    = ST_DONE;
        end else if (wd_expired) begin
          b_ready_next    = 1'b0;
          resp_err_next   = 1'b1;
          resp_rdata_next = '0;
          state_next      = ST_DONE;
        end
      end

      ST_RADDR: begin
        if (ARready) begin
          ar_valid_next = 1'b0;
          r_ready_next  = 1'b1;
          state_next    = ST_RDATA;
        end else if (wd_expired) begin
          ar_valid_next   = 1'b0;
          resp_err_next   = 1'b1;
          resp_rdata_next = '0;
          state_next      = ST_DONE;
        end
      end

      ST_RDATA: begin
        if (Rvalid) begin
          resp_rdata_next = Rdata;
          r_ready_next    = 1'b0;
          resp_err_next   = 1'b0;
          state_next      = ST_DONE;
        end else if (wd_expired) begin
          r_ready_next    = 1'b0;
          resp_err_next   = 1'b1;
          resp_rdata_next = '0;
          state_next      = ST_DONE;
        end
      end

      ST_DONE: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      AWvalid    <= 1'b0;
      Wvalid     <= 1'b0;
      Bready     <= 1'b0;
      ARvalid    <= 1'b0;
      Rready     <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      AWaddr     <= '0;
      Wdata      <= '0;
      ARaddr     <= '0;
    end else begin
      state      <= state_next;
      AWvalid    <= aw_valid_next;
      Wvalid     <= w_valid_next;
      Bready     <= b_ready_next;
      ARvalid    <= ar_valid_next;
      Rready     <= r_ready_next;
      resp_err   <= resp_err_next;
      resp_rdata <= resp_rdata_next;
      AWaddr     <= aw_addr_next;
      Wdata      <= w_data_next;
      ARaddr     <= ar_addr_next;
    end
  end

endmodule
